// File: rtl/cam_pkg.sv
// Shared CAM definitions: controller state encoding and SRL geometry helpers.
package cam_pkg;

   // Controller states; encodings are fixed so other CAM variants agree.
   typedef enum logic [1:0] {
      INIT   = 2'd0,
      IDLE   = 2'd1,
      WRITE  = 2'd2,
      DELETE = 2'd3
   } cam_state_t;

   // Number of shift-register slices needed to cover a key.
   function automatic int unsigned slice_count(input int unsigned data_width,
                                               input int unsigned slice_width);
      return (data_width + slice_width - 1) / slice_width;
   endfunction

   // Depth of one slice shift register (one bit per slice value).
   function automatic int unsigned ram_depth(input int unsigned slice_width);
      return 32'd1 << slice_width;
   endfunction

endpackage

// File: rtl/cam_srl_ternary_if.sv
// Write-command, search and match bundle of the SRL CAM.
interface cam_srl_ternary_if #(
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ADDR_WIDTH = 5
);
   localparam int unsigned ROWS = 32'd1 << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] write_addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] write_mask;
   logic                  write_delete;
   logic                  write_valid;
   logic                  write_ready;
   logic [DATA_WIDTH-1:0] compare_data;
   logic                  compare_valid;
   logic [ROWS-1:0]       match_many;
   logic [ROWS-1:0]       match_single;
   logic [ROWS-1:0]       entry_valid;
   logic [ADDR_WIDTH-1:0] match_addr;
   logic                  match;
   logic                  match_valid;

   modport master (
      output write_addr, write_data, write_mask, write_delete, write_valid,
             compare_data, compare_valid,
      input  write_ready, match_many, match_single, entry_valid,
             match_addr, match, match_valid
   );

   modport slave (
      input  write_addr, write_data, write_mask, write_delete, write_valid,
             compare_data, compare_valid,
      output write_ready, match_many, match_single, entry_valid,
             match_addr, match, match_valid
   );

endinterface

// File: rtl/priority_encoder.sv
// Combinational priority encoder: index of the winning set bit plus its one-hot.
module priority_encoder #(
   parameter int unsigned WIDTH        = 32,
   parameter string       LSB_PRIORITY = "HIGH"
) (
   input  logic [WIDTH-1:0]                                   input_unencoded,
   output logic                                               output_valid,
   output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]       output_encoded,
   output logic [WIDTH-1:0]                                   output_unencoded
);
   localparam int unsigned ENC_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam bit          LSB_HIGH  = (LSB_PRIORITY == "HIGH");

   logic                 found;
   logic [ENC_WIDTH-1:0] enc;

   // Scan toward the preferred end so the last hit seen is the winner.
   always_comb begin
      found = 1'b0;
      enc   = '0;
      if (LSB_HIGH) begin
         for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (input_unencoded[i]) begin
               found = 1'b1;
               enc   = ENC_WIDTH'(i);
            end
         end
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (input_unencoded[i]) begin
               found = 1'b1;
               enc   = ENC_WIDTH'(i);
            end
         end
      end
   end

   assign output_valid     = found;
   assign output_encoded   = enc;
   assign output_unencoded = found ? (WIDTH'(1) << enc) : '0;

endmodule

// File: rtl/cam_srl_ternary.sv
// Shift-register (SRL) based CAM. Each row holds SLICE_COUNT slice shift
// registers of depth 2**SLICE_WIDTH; bit v of a slice is 1 when slice value v
// matches the stored key. A write rebuilds a row over 2**SLICE_WIDTH cycles.
// Define CAM_SRL_TERNARY_EN to honour write_mask (ternary CAM); otherwise the
// mask is ignored and the CAM matches exactly.
module cam_srl_ternary
   import cam_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned ADDR_WIDTH   = 5,
   parameter int unsigned SLICE_WIDTH  = 4,
   parameter string       LSB_PRIORITY = "HIGH"
) (
   input  logic               clk,
   input  logic               rst,
   cam_srl_ternary_if.slave   bus
);
   localparam int unsigned ROWS        = 32'd1 << ADDR_WIDTH;
   localparam int unsigned SLICE_COUNT = slice_count(DATA_WIDTH, SLICE_WIDTH);
   localparam int unsigned RAM_DEPTH   = ram_depth(SLICE_WIDTH);
   localparam int unsigned PAD_WIDTH   = SLICE_COUNT * SLICE_WIDTH;

   cam_state_t              state_q;
   logic [SLICE_WIDTH-1:0]  count_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [PAD_WIDTH-1:0]    data_q;
   logic                    write_ready_q;
   logic [ROWS-1:0]         entry_valid_q;
   logic [ROWS-1:0]         match_many_q;
   logic                    match_valid_q;

   logic [PAD_WIDTH-1:0]    cmp_pad;
   logic [SLICE_COUNT-1:0]  shift_bit;
   logic [ROWS-1:0]         shift_en;
   logic [ROWS-1:0]         raw_match;

`ifdef CAM_SRL_TERNARY_EN
   logic [PAD_WIDTH-1:0]    mask_q;

   // Mask register, loaded with the command.
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
      end else if (state_q == IDLE && bus.write_valid && write_ready_q) begin
         mask_q <= PAD_WIDTH'(bus.write_mask);
      end
   end
`else
   logic unused_mask;
   assign unused_mask = ^bus.write_mask;
`endif

   assign cmp_pad = PAD_WIDTH'(bus.compare_data);

   // Command controller: init sweep, accept, shift count and entry valid flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= INIT;
         count_q       <= '1;
         addr_q        <= '0;
         data_q        <= '0;
         write_ready_q <= 1'b0;
         entry_valid_q <= '0;
      end else begin
         case (state_q)
            INIT: begin
               count_q <= count_q - SLICE_WIDTH'(1);
               if (count_q == '0) begin
                  state_q       <= IDLE;
                  write_ready_q <= 1'b1;
               end
            end
            IDLE: begin
               if (bus.write_valid && write_ready_q) begin
                  addr_q                        <= bus.write_addr;
                  data_q                        <= PAD_WIDTH'(bus.write_data);
                  count_q                       <= '1;
                  write_ready_q                 <= 1'b0;
                  entry_valid_q[bus.write_addr] <= 1'b0;
                  state_q                       <= bus.write_delete ? DELETE : WRITE;
               end
            end
            WRITE, DELETE: begin
               count_q <= count_q - SLICE_WIDTH'(1);
               if (count_q == '0) begin
                  state_q       <= IDLE;
                  write_ready_q <= 1'b1;
                  if (state_q == WRITE) begin
                     entry_valid_q[addr_q] <= 1'b1;
                  end
               end
            end
            default: begin
               state_q       <= INIT;
               count_q       <= '1;
               write_ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Rows being rebuilt: all of them during init, only the target during a command.
   always_comb begin
      shift_en = '0;
      for (int r = 0; r < int'(ROWS); r++) begin
         shift_en[r] = (state_q == INIT) ||
                       (((state_q == WRITE) || (state_q == DELETE)) &&
                        (addr_q == ADDR_WIDTH'(r)));
      end
   end

   // Per-slice bit shifted in this cycle: does slice value 'count' match the key?
   for (genvar s = 0; s < int'(SLICE_COUNT); s++) begin : g_bit
`ifdef CAM_SRL_TERNARY_EN
      assign shift_bit[s] = (state_q == WRITE) &&
         (((count_q ^ data_q[s*SLICE_WIDTH +: SLICE_WIDTH]) &
           ~mask_q[s*SLICE_WIDTH +: SLICE_WIDTH]) == '0);
`else
      assign shift_bit[s] = (state_q == WRITE) &&
         (count_q == data_q[s*SLICE_WIDTH +: SLICE_WIDTH]);
`endif
   end

   for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
      logic [SLICE_COUNT-1:0] hit;

      for (genvar s = 0; s < int'(SLICE_COUNT); s++) begin : g_slice
         logic [RAM_DEPTH-1:0] srl;

         // Slice lookup table, filled one value per cycle from the top down.
         always_ff @(posedge clk) begin
            if (!rst && shift_en[r]) begin
               srl <= {srl[RAM_DEPTH-2:0], shift_bit[s]};
            end
         end

         assign hit[s] = srl[cmp_pad[s*SLICE_WIDTH +: SLICE_WIDTH]];
      end

      assign raw_match[r] = (&hit) && entry_valid_q[r] && !shift_en[r];
   end

   // Registered search result, one cycle after the key is sampled.
   always_ff @(posedge clk) begin
      if (rst) begin
         match_many_q  <= '0;
         match_valid_q <= 1'b0;
      end else begin
         match_many_q  <= raw_match;
         match_valid_q <= bus.compare_valid;
      end
   end

   priority_encoder #(
      .WIDTH        (ROWS),
      .LSB_PRIORITY (LSB_PRIORITY)
   ) u_enc (
      .input_unencoded  (match_many_q),
      .output_valid     (bus.match),
      .output_encoded   (bus.match_addr),
      .output_unencoded (bus.match_single)
   );

   assign bus.write_ready = write_ready_q;
   assign bus.entry_valid = entry_valid_q;
   assign bus.match_many  = match_many_q;
   assign bus.match_valid = match_valid_q;

endmodule

// File: tb/tb_cam_srl_ternary.sv
// Bench for cam_srl_ternary: two instances (LSB_PRIORITY HIGH and LOW) share
// every input; a table of directed vectors, hand sequences for delete,
// overwrite and mid-command reset, then random traffic against a key model.
module tb_cam_srl_ternary;
   localparam int unsigned DW   = 64;
   localparam int unsigned AW   = 5;
   localparam int unsigned SW   = 4;
   localparam int unsigned ROWS = 32;
`ifdef CAM_SRL_TERNARY_EN
   localparam bit TERN = 1'b1;
`else
   localparam bit TERN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] write_addr = '0;
   logic [DW-1:0] write_data = '0;
   logic [DW-1:0] write_mask = '0;
   logic          write_delete = 1'b0;
   logic          write_valid = 1'b0;
   logic [DW-1:0] compare_data = '0;
   logic          compare_valid = 1'b0;

   int checks = 0;
   int errors = 0;

   cam_srl_ternary_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_hi ();
   cam_srl_ternary_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_lo ();

   assign bus_hi.write_addr    = write_addr;
   assign bus_hi.write_data    = write_data;
   assign bus_hi.write_mask    = write_mask;
   assign bus_hi.write_delete  = write_delete;
   assign bus_hi.write_valid   = write_valid;
   assign bus_hi.compare_data  = compare_data;
   assign bus_hi.compare_valid = compare_valid;
   assign bus_lo.write_addr    = write_addr;
   assign bus_lo.write_data    = write_data;
   assign bus_lo.write_mask    = write_mask;
   assign bus_lo.write_delete  = write_delete;
   assign bus_lo.write_valid   = write_valid;
   assign bus_lo.compare_data  = compare_data;
   assign bus_lo.compare_valid = compare_valid;

   cam_srl_ternary #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW), .LSB_PRIORITY("HIGH"))
      dut_hi (.clk(clk), .rst(rst), .bus(bus_hi.slave));
   cam_srl_ternary #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(SW), .LSB_PRIORITY("LOW"))
      dut_lo (.clk(clk), .rst(rst), .bus(bus_lo.slave));

   always #5 clk = ~clk;

   // Reference model: what each entry stores, as plain key/mask records.
   logic          m_valid [ROWS];
   logic [DW-1:0] m_data  [ROWS];
   logic [DW-1:0] m_mask  [ROWS];

   function automatic logic [ROWS-1:0] model_many(input logic [DW-1:0] key);
      logic [ROWS-1:0] res = '0;
      for (int r = 0; r < int'(ROWS); r++)
         if (m_valid[r] && (((key ^ m_data[r]) & ~m_mask[r]) == '0)) res[r] = 1'b1;
      return res;
   endfunction

   function automatic logic [ROWS-1:0] model_ev();
      logic [ROWS-1:0] res = '0;
      for (int r = 0; r < int'(ROWS); r++) res[r] = m_valid[r];
      return res;
   endfunction

   task automatic model_clear();
      for (int r = 0; r < int'(ROWS); r++) begin
         m_valid[r] = 1'b0;
         m_data[r]  = '0;
         m_mask[r]  = '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Tick until write_ready rises, bounded; n is the number of ticks taken.
   task automatic wait_ready(output int n);
      n = 0;
      while (bus_hi.write_ready !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
   endtask

   task automatic accept(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [DW-1:0] m, input logic del);
      int n;
      wait_ready(n);
      chk("ready_before_cmd", 64'(bus_hi.write_ready), 64'd1);
      write_addr   = a;
      write_data   = d;
      write_mask   = m;
      write_delete = del;
      write_valid  = 1'b1;
      tick();
      write_valid  = 1'b0;
      chk("ready_drop_hi", 64'(bus_hi.write_ready), 64'd0);
      chk("ready_drop_lo", 64'(bus_lo.write_ready), 64'd0);
      chk("ev_clear_at_accept", 64'(bus_hi.entry_valid[a]), 64'd0);
   endtask

   task automatic model_store(input logic [AW-1:0] a, input logic [DW-1:0] d,
                              input logic [DW-1:0] m, input logic del);
      m_valid[a] = !del;
      m_data[a]  = d;
      m_mask[a]  = TERN ? m : '0;
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [DW-1:0] m, input logic del);
      int n;
      accept(a, d, m, del);
      wait_ready(n);
      chk("busy_cycles", 64'(n), 64'd16);
      model_store(a, d, m, del);
      chk("entry_valid_hi", 64'(bus_hi.entry_valid), 64'(model_ev()));
      chk("entry_valid_lo", 64'(bus_lo.entry_valid), 64'(model_ev()));
   endtask

   // One search; expectations for both priority orders derived from exp.
   task automatic do_cmp(input logic [DW-1:0] key, input logic [ROWS-1:0] exp, input string tag);
      int lo_idx = 0;
      int hi_idx = 0;
      logic hit;
      hit = |exp;
      for (int r = int'(ROWS) - 1; r >= 0; r--) if (exp[r]) lo_idx = r;
      for (int r = 0; r < int'(ROWS); r++) if (exp[r]) hi_idx = r;
      compare_data  = key;
      compare_valid = 1'b1;
      tick();
      compare_valid = 1'b0;
      chk({tag, "_many_hi"}, 64'(bus_hi.match_many), 64'(exp));
      chk({tag, "_many_lo"}, 64'(bus_lo.match_many), 64'(exp));
      chk({tag, "_match"}, 64'(bus_hi.match), 64'(hit));
      chk({tag, "_addr_hi"}, 64'(bus_hi.match_addr), 64'(lo_idx));
      chk({tag, "_single_hi"}, 64'(bus_hi.match_single), hit ? (64'd1 << lo_idx) : 64'd0);
      chk({tag, "_addr_lo"}, 64'(bus_lo.match_addr), 64'(hi_idx));
      chk({tag, "_single_lo"}, 64'(bus_lo.match_single), hit ? (64'd1 << hi_idx) : 64'd0);
      chk({tag, "_mvalid"}, 64'(bus_hi.match_valid), 64'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ready"}, 64'(bus_hi.write_ready), 64'd0);
      chk({tag, "_ev"}, 64'(bus_hi.entry_valid), 64'd0);
      chk({tag, "_many"}, 64'(bus_hi.match_many), 64'd0);
      chk({tag, "_mvalid"}, 64'(bus_hi.match_valid), 64'd0);
      chk({tag, "_match"}, 64'(bus_hi.match), 64'd0);
      chk({tag, "_addr"}, 64'(bus_lo.match_addr), 64'd0);
      chk({tag, "_single"}, 64'(bus_lo.match_single), 64'd0);
   endtask

   typedef struct {
      int              op;    // 0 write, 1 delete, 2 compare
      logic [AW-1:0]   addr;
      logic [DW-1:0]   data;
      logic [DW-1:0]   mask;
      logic [ROWS-1:0] exp;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int n;
      int unsigned k;
      logic [AW-1:0] ra;
      logic [DW-1:0] rd, rm, key;

      vecs[0]  = '{2, 5'd0, 64'h0,                  64'h0, 32'h0};
      vecs[1]  = '{0, 5'd3, 64'hDEADBEEF00000001,   64'h0, 32'h0};
      vecs[2]  = '{2, 5'd0, 64'hDEADBEEF00000001,   64'h0, 32'h0000_0008};
      vecs[3]  = '{0, 5'd7, 64'h1234,               64'hF, 32'h0};
      vecs[4]  = '{2, 5'd0, 64'h1234,               64'h0, 32'h0000_0080};
      vecs[5]  = '{2, 5'd0, 64'h1230,               64'h0, TERN ? 32'h0000_0080 : 32'h0};
      vecs[6]  = '{2, 5'd0, 64'h123F,               64'h0, TERN ? 32'h0000_0080 : 32'h0};
      vecs[7]  = '{2, 5'd0, 64'h1240,               64'h0, 32'h0};
      vecs[8]  = '{0, 5'd2, 64'hCAFE,               64'h0, 32'h0};
      vecs[9]  = '{0, 5'd9, 64'hCAFE,               64'h0, 32'h0};
      vecs[10] = '{2, 5'd0, 64'hCAFE,               64'h0, 32'h0000_0204};
      vecs[11] = '{2, 5'd0, 64'hDEADBEEF00000000,   64'h0, 32'h0};

      model_clear();

      // Reset values, then the init sweep length.
      repeat (3) tick();
      chk_reset_outputs("in_reset");
      rst = 1'b0;
      wait_ready(n);
      chk("init_cycles", 64'(n), 64'd16);
      chk("init_ev", 64'(bus_hi.entry_valid), 64'd0);

      // Directed table.
      for (int i = 0; i < 12; i++) begin
         case (vecs[i].op)
            0: do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, 1'b0);
            1: do_write(vecs[i].addr, vecs[i].data, vecs[i].mask, 1'b1);
            default: do_cmp(vecs[i].data, vecs[i].exp, $sformatf("vec%0d", i));
         endcase
      end
      tick();
      chk("mvalid_drops", 64'(bus_hi.match_valid), 64'd0);

      // Delete addr 3: invisible to the very next search.
      accept(5'd3, 64'h0, 64'h0, 1'b1);
      do_cmp(64'hDEADBEEF00000001, 32'h0, "del_immediate");
      wait_ready(n);
      chk("del_busy", 64'(n), 64'd15);
      model_store(5'd3, 64'h0, 64'h0, 1'b1);
      do_cmp(64'hDEADBEEF00000001, 32'h0, "del_after");

      // Overwrite addr 9: blocked throughout the shifts, addr 2 unaffected.
      accept(5'd9, 64'hBEEF, 64'h0, 1'b0);
      compare_data  = 64'hCAFE;
      compare_valid = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
         chk("ovw_blocks9", 64'(bus_hi.match_many[9]), 64'd0);
         chk("ovw_keeps2", 64'(bus_hi.match_many[2]), 64'd1);
         chk("ovw_lo_addr", 64'(bus_lo.match_addr), 64'd2);
      end while (bus_hi.write_ready !== 1'b1 && n < 40);
      compare_valid = 1'b0;
      chk("ovw_busy", 64'(n), 64'd16);
      model_store(5'd9, 64'hBEEF, 64'h0, 1'b0);
      do_cmp(64'hBEEF, 32'h0000_0200, "ovw_new_hit");
      do_cmp(64'hCAFE, 32'h0000_0004, "ovw_old_gone");

      // Reset eight shifts into a write of addr 5.
      accept(5'd5, 64'h5555, 64'h0, 1'b0);
      repeat (8) tick();
      rst = 1'b1;
      tick();
      chk_reset_outputs("mid_rst");
      rst = 1'b0;
      wait_ready(n);
      chk("reinit_cycles", 64'(n), 64'd16);
      model_clear();
      chk("reinit_ev", 64'(bus_hi.entry_valid), 64'd0);
      do_cmp(64'h5555, 32'h0, "partial_key");
      do_cmp(64'hBEEF, 32'h0, "post_rst_old");

      // Random traffic against the model, small key space to force collisions.
      for (int i = 0; i < 40; i++) begin
         k  = $urandom_range(0, 3);
         ra = AW'($urandom_range(0, 7));
         if (k == 0) begin
            rd = ($urandom_range(0, 1) == 1) ? 64'($urandom_range(0, 15))
                                             : {$urandom, $urandom};
            rm = ($urandom_range(0, 1) == 1) ? 64'h0F : 64'h0;
            do_write(ra, rd, rm, 1'b0);
         end else if (k == 1) begin
            do_write(ra, 64'h0, 64'h0, 1'b1);
         end else begin
            if (m_valid[ra] && $urandom_range(0, 1) == 1)
               key = m_data[ra] ^ ({$urandom, $urandom} & m_mask[ra]);
            else
               key = 64'($urandom_range(0, 15));
            do_cmp(key, model_many(key), "rand");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
